// File: rtl/memref_pkg.sv
// memref_pkg: shared types and defaults for the memref responder.
// Holds the FSM encoding, default geometry and counter width.
package memref_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_LOAD
  } state_e;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SIZE  = 1024;
  localparam int CNT_W     = 32;

endpackage

// File: rtl/memref_resp_2p_if.sv
// memref_resp_2p_if: read port p0, write port p1 and init stream.
// master = kernel/loader side, slave = memory responder side.
interface memref_resp_2p_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
) ();

  logic              p0_addr_en;
  logic [ADDR_W-1:0] p0_addr_data;
  logic              p0_rd_en;
  logic [WIDTH-1:0]  p0_rd_data;
  logic              p0_rd_valid;

  logic              p1_addr_en;
  logic [ADDR_W-1:0] p1_addr_data;
  logic              p1_wr_en;
  logic [WIDTH-1:0]  p1_wr_data;

  logic              init_valid;
  logic              init_ready;
  logic [WIDTH-1:0]  init_data;
  logic              init_last;

  modport master (
    output p0_addr_en, p0_addr_data, p0_rd_en,
    input  p0_rd_data, p0_rd_valid,
    output p1_addr_en, p1_addr_data, p1_wr_en,
    output p1_wr_data,
    output init_valid, init_data, init_last,
    input  init_ready
  );

  modport slave (
    input  p0_addr_en, p0_addr_data, p0_rd_en,
    output p0_rd_data, p0_rd_valid,
    input  p1_addr_en, p1_addr_data, p1_wr_en,
    input  p1_wr_data,
    input  init_valid, init_data, init_last,
    output init_ready
  );

endinterface

// File: rtl/memref_rd_pipe.sv
// memref_rd_pipe: RD_LAT-deep {valid,data} delay line.
// Data only advances with valid, so the tail holds the last response.
module memref_rd_pipe #(
  parameter int WIDTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic [RD_LAT-1:0] vld;
  logic [WIDTH-1:0]  dat [RD_LAT];

  // shift valids every cycle, move data only behind a valid
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        dat[i] <= '0;
      end
    end else begin
      vld[0] <= in_valid;
      if (in_valid) begin
        dat[0] <= in_data;
      end
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        if (vld[i-1]) begin
          dat[i] <= dat[i-1];
        end
      end
    end
  end

  assign out_valid = vld[RD_LAT-1];
  assign out_data  = dat[RD_LAT-1];

endmodule

// File: rtl/memref_resp_2p.sv
// memref_resp_2p: 1R/1W memref responder with init-stream preload.
// Optional macro MEMREF_BOUNDS_CHECK_EN adds the sticky err_oob flag.
module memref_resp_2p
  import memref_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SIZE   = DEF_SIZE,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  memref_resp_2p_if.slave  bus,
  output logic             busy,
  output logic             req_in_load,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
`ifdef MEMREF_BOUNDS_CHECK_EN
  ,
  output logic             err_oob
`endif
);

  localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(SIZE);
  localparam logic [IW-1:0] LAST = IW'(SIZE - 1);

  state_e          state;
  logic [IW-1:0]   load_ptr;
  logic [WIDTH-1:0] mem [SIZE];

  logic             rd_in_rng;
  logic             wr_in_rng;
  logic             rd_acc;
  logic             wr_acc;
  logic             beat;
  logic [IW-1:0]    rd_idx;
  logic [IW-1:0]    wr_idx;
  logic [WIDTH-1:0] rd_word;
  logic             mem_we;
  logic [IW-1:0]    mem_wa;
  logic [WIDTH-1:0] mem_wd;

  assign rd_in_rng = {1'b0, bus.p0_addr_data} < LIM;
  assign wr_in_rng = {1'b0, bus.p1_addr_data} < LIM;
  assign rd_idx    = bus.p0_addr_data[IW-1:0];
  assign wr_idx    = bus.p1_addr_data[IW-1:0];

  assign rd_acc = !rst && (state == ST_IDLE) && bus.p0_rd_en;
  assign wr_acc = !rst && (state == ST_IDLE) && bus.p1_wr_en
                  && wr_in_rng;
  assign beat   = !rst && (state == ST_LOAD) && bus.init_valid
                  && bus.init_ready;

  // out-of-range reads answer zero without touching the array
  assign rd_word = rd_in_rng ? mem[rd_idx] : '0;

  // load and p1 never overlap: p1 is only served in IDLE
  assign mem_we = beat | wr_acc;
  assign mem_wa = beat ? load_ptr : wr_idx;
  assign mem_wd = beat ? bus.init_data : bus.p1_wr_data;

  // single write port; old data is read out in the same cycle
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  // load FSM with registered busy/init_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      load_ptr       <= '0;
      busy           <= 1'b0;
      bus.init_ready <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (bus.init_valid) begin
            state          <= ST_LOAD;
            load_ptr       <= '0;
            busy           <= 1'b1;
            bus.init_ready <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (beat) begin
            if (bus.init_last || load_ptr == LAST) begin
              state          <= ST_IDLE;
              load_ptr       <= '0;
              busy           <= 1'b0;
              bus.init_ready <= 1'b0;
            end else begin
              load_ptr <= load_ptr + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // access counters and sticky load-interference flag
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_count    <= '0;
      wr_count    <= '0;
      req_in_load <= 1'b0;
    end else begin
      if (rd_acc) begin
        rd_count <= rd_count + 1'b1;
      end
      if (wr_acc) begin
        wr_count <= wr_count + 1'b1;
      end
      if (state == ST_LOAD && (bus.p0_rd_en || bus.p1_wr_en)) begin
        req_in_load <= 1'b1;
      end
    end
  end

`ifdef MEMREF_BOUNDS_CHECK_EN
  logic p0_bad;
  logic p1_bad;

  assign p0_bad = (bus.p0_rd_en && !rd_in_rng)
                  || (bus.p0_addr_en != bus.p0_rd_en);
  assign p1_bad = (bus.p1_wr_en && !wr_in_rng)
                  || (bus.p1_addr_en != bus.p1_wr_en);

  // sticky bounds/enable-mismatch flag
  always_ff @(posedge clk) begin
    if (rst) begin
      err_oob <= 1'b0;
    end else if (p0_bad || p1_bad) begin
      err_oob <= 1'b1;
`ifndef SYNTHESIS
      $error("memref_resp_2p: bad access p0=%0h p1=%0h",
             bus.p0_addr_data, bus.p1_addr_data);
`endif
    end
  end
`else
  logic unused_addr_en;
  assign unused_addr_en = bus.p0_addr_en ^ bus.p1_addr_en;
`endif

  memref_rd_pipe #(
    .WIDTH  (WIDTH),
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_acc),
    .in_data   (rd_word),
    .out_valid (bus.p0_rd_valid),
    .out_data  (bus.p0_rd_data)
  );

endmodule

// File: tb/tb_memref_resp_2p.sv
// tb_memref_resp_2p: directed bench, SIZE=1000, RD_LAT=3.
// Checks load, read-first collision, bounds, interference and resets.
module tb_memref_resp_2p;

  localparam int W  = 32;
  localparam int AW = 10;
  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  logic        req_in_load;
  logic [31:0] rd_count;
  logic [31:0] wr_count;
`ifdef MEMREF_BOUNDS_CHECK_EN
  logic        err_oob;
`endif

  int n_cmp = 0;
  int n_err = 0;

  memref_resp_2p_if #(.WIDTH(W), .ADDR_W(AW)) bus ();

  memref_resp_2p #(
    .WIDTH  (W),
    .SIZE   (1000),
    .ADDR_W (AW),
    .RD_LAT (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .req_in_load (req_in_load),
    .rd_count    (rd_count),
    .wr_count    (wr_count)
`ifdef MEMREF_BOUNDS_CHECK_EN
    ,
    .err_oob     (err_oob)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_rd(input logic en, input logic [AW-1:0] a);
    bus.p0_rd_en     = en;
    bus.p0_addr_en   = en;
    bus.p0_addr_data = a;
  endtask

  task automatic set_wr(input logic en, input logic [AW-1:0] a,
                        input logic [W-1:0] d);
    bus.p1_wr_en     = en;
    bus.p1_addr_en   = en;
    bus.p1_addr_data = a;
    bus.p1_wr_data   = d;
  endtask

  task automatic set_init(input logic v, input logic [W-1:0] d,
                          input logic l);
    bus.init_valid = v;
    bus.init_data  = d;
    bus.init_last  = l;
  endtask

  task automatic rd_check(input string tag, input logic [AW-1:0] a,
                          input logic [W-1:0] exp);
    set_rd(1'b1, a);
    step();
    set_rd(1'b0, '0);
    step();
    chk({tag, "_early"}, bus.p0_rd_valid, 1'b0);
    step();
    chk({tag, "_vld"}, bus.p0_rd_valid, 1'b1);
    chk({tag, "_dat"}, bus.p0_rd_data, exp);
  endtask

  initial begin
    set_rd(1'b0, '0);
    set_wr(1'b0, '0, '0);
    set_init(1'b0, '0, 1'b0);
    step();
    step();
    chk("rst_vld", bus.p0_rd_valid, 1'b0);
    chk("rst_dat", bus.p0_rd_data, '0);
    chk("rst_rdy", bus.init_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ril", req_in_load, 1'b0);
    chk("rst_rdc", rd_count, '0);
    chk("rst_wrc", wr_count, '0);
    rst = 1'b0;

    // preload 4 words
    set_init(1'b1, 32'h11, 1'b0);
    step();
    chk("ld_busy", busy, 1'b1);
    chk("ld_rdy", bus.init_ready, 1'b1);
    step();
    set_init(1'b1, 32'h22, 1'b0);
    step();
    set_init(1'b1, 32'h33, 1'b0);
    step();
    chk("ld_busy3", busy, 1'b1);
    set_init(1'b1, 32'h44, 1'b1);
    step();
    set_init(1'b0, '0, 1'b0);
    chk("ld_done", busy, 1'b0);
    chk("ld_rdy0", bus.init_ready, 1'b0);

    // back-to-back reads of 0..3
    set_rd(1'b1, 10'd0);
    step();
    chk("b2b_v0", bus.p0_rd_valid, 1'b0);
    set_rd(1'b1, 10'd1);
    step();
    chk("b2b_v1", bus.p0_rd_valid, 1'b0);
    set_rd(1'b1, 10'd2);
    step();
    chk("b2b_d0", bus.p0_rd_data, 32'h11);
    chk("b2b_q0", bus.p0_rd_valid, 1'b1);
    set_rd(1'b1, 10'd3);
    step();
    chk("b2b_d1", bus.p0_rd_data, 32'h22);
    set_rd(1'b0, '0);
    step();
    chk("b2b_d2", bus.p0_rd_data, 32'h33);
    step();
    chk("b2b_d3", bus.p0_rd_data, 32'h44);
    chk("b2b_q3", bus.p0_rd_valid, 1'b1);
    step();
    chk("b2b_idle", bus.p0_rd_valid, 1'b0);
    chk("b2b_hold", bus.p0_rd_data, 32'h44);
    chk("b2b_rdc", rd_count, 32'd4);

    // read-first collision on addr 5
    set_wr(1'b1, 10'd5, 32'hA);
    step();
    set_wr(1'b1, 10'd5, 32'hB);
    set_rd(1'b1, 10'd5);
    step();
    set_wr(1'b0, '0, '0);
    step();
    set_rd(1'b0, '0);
    step();
    chk("col_old", bus.p0_rd_data, 32'hA);
    step();
    chk("col_new", bus.p0_rd_data, 32'hB);
    chk("col_wrc", wr_count, 32'd2);
    step();

    // bounds: last valid word, then past the end
    set_wr(1'b1, 10'd999, 32'h99);
    step();
    set_wr(1'b0, '0, '0);
    rd_check("top", 10'd999, 32'h99);
    rd_check("oob_rd", 10'd1010, 32'h0);
    set_wr(1'b1, 10'd1010, 32'h5);
    step();
    set_wr(1'b0, '0, '0);
    chk("oob_wrc", wr_count, 32'd3);
    chk("oob_rdc", rd_count, 32'd8);
`ifdef MEMREF_BOUNDS_CHECK_EN
    chk("oob_err", err_oob, 1'b1);
`endif

    // requests while loading are dropped
    set_init(1'b1, 32'h66, 1'b0);
    step();
    set_init(1'b0, '0, 1'b0);
    set_rd(1'b1, 10'd2);
    set_wr(1'b1, 10'd3, 32'hDEAD);
    step();
    set_rd(1'b0, '0);
    set_wr(1'b0, '0, '0);
    chk("ril_set", req_in_load, 1'b1);
    step();
    step();
    chk("ril_nov", bus.p0_rd_valid, 1'b0);
    step();
    chk("ril_nov2", bus.p0_rd_valid, 1'b0);
    chk("ril_rdc", rd_count, 32'd8);
    chk("ril_wrc", wr_count, 32'd3);
    set_init(1'b1, 32'h66, 1'b1);
    step();
    set_init(1'b0, '0, 1'b0);
    chk("ril_busy", busy, 1'b0);
    rd_check("ril_drop", 10'd3, 32'h44);
    rd_check("ril_ld0", 10'd0, 32'h66);
    chk("ril_stk", req_in_load, 1'b1);
    chk("ril_rdc2", rd_count, 32'd10);

    // reset after 2 of 4 beats
    set_init(1'b1, 32'h71, 1'b0);
    step();
    step();
    set_init(1'b1, 32'h72, 1'b0);
    step();
    set_init(1'b0, '0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rml_busy", busy, 1'b0);
    chk("rml_rdc", rd_count, '0);
    chk("rml_ril", req_in_load, 1'b0);
    rd_check("rml_m0", 10'd0, 32'h71);
    rd_check("rml_m1", 10'd1, 32'h72);
    rd_check("rml_m2", 10'd2, 32'h33);
    set_init(1'b1, 32'h81, 1'b1);
    step();
    step();
    set_init(1'b0, '0, 1'b0);
    rd_check("rml_re0", 10'd0, 32'h81);
    rd_check("rml_re1", 10'd1, 32'h72);

    // reset while a read is in flight
    set_rd(1'b1, 10'd0);
    step();
    set_rd(1'b0, '0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmr_v0", bus.p0_rd_valid, 1'b0);
    chk("rmr_d0", bus.p0_rd_data, '0);
    step();
    chk("rmr_v1", bus.p0_rd_valid, 1'b0);
    step();
    chk("rmr_v2", bus.p0_rd_valid, 1'b0);

    // throughput: 16 words, 16 back-to-back reads
    set_init(1'b1, 32'h100, 1'b0);
    step();
    for (int i = 0; i < 16; i++) begin
      set_init(1'b1, 32'h100 + i, i == 15);
      step();
    end
    set_init(1'b0, '0, 1'b0);
    chk("tp_busy", busy, 1'b0);
    for (int c = 0; c < 19; c++) begin
      if (c < 16) set_rd(1'b1, AW'(c));
      else set_rd(1'b0, '0);
      step();
      if (c >= 2 && c < 18) begin
        chk($sformatf("tp_v%0d", c - 2), bus.p0_rd_valid, 1'b1);
        chk($sformatf("tp_d%0d", c - 2), bus.p0_rd_data,
            64'(32'h100 + c - 2));
      end else begin
        chk($sformatf("tp_n%0d", c), bus.p0_rd_valid, 1'b0);
      end
    end
    chk("tp_rdc", rd_count, 32'd16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
